// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: opcodes, FSM states,
// ALU operation codes and datapath mux selects.
package mips_ctrl_pkg;

   localparam logic [5:0] OpRType = 6'b000000;
   localparam logic [5:0] OpJ     = 6'b000010;
   localparam logic [5:0] OpJal   = 6'b000011;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpBne   = 6'b000101;
   localparam logic [5:0] OpAddi  = 6'b001000;
   localparam logic [5:0] OpAndi  = 6'b001100;
   localparam logic [5:0] OpOri   = 6'b001101;
   localparam logic [5:0] OpLui   = 6'b001111;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] FunctJr = 6'b001000;

   typedef enum logic [3:0] {
      StFetch    = 4'd0,
      StDecode   = 4'd1,
      StMemAddr  = 4'd2,
      StMemRead  = 4'd3,
      StMemWb    = 4'd4,
      StMemWrite = 4'd5,
      StRExec    = 4'd6,
      StRWb      = 4'd7,
      StIExec    = 4'd8,
      StIWb      = 4'd9,
      StBranch   = 4'd10,
      StJump     = 4'd11,
      StJal      = 4'd12,
      StJr       = 4'd13
   } stateT;

   localparam logic [2:0] AluAdd   = 3'b000;
   localparam logic [2:0] AluSub   = 3'b001;
   localparam logic [2:0] AluFunct = 3'b010;
   localparam logic [2:0] AluAnd   = 3'b011;
   localparam logic [2:0] AluOr    = 3'b100;
   localparam logic [2:0] AluLui   = 3'b101;

   localparam logic [1:0] PcSrcAlu    = 2'b00;
   localparam logic [1:0] PcSrcAluOut = 2'b01;
   localparam logic [1:0] PcSrcJump   = 2'b10;
   localparam logic [1:0] PcSrcRs     = 2'b11;

   localparam logic [1:0] RegDstRt = 2'b00;
   localparam logic [1:0] RegDstRd = 2'b01;
   localparam logic [1:0] RegDstRa = 2'b10;

   localparam logic [1:0] MemToRegAluOut = 2'b00;
   localparam logic [1:0] MemToRegMdr    = 2'b01;
   localparam logic [1:0] MemToRegPc     = 2'b10;

   localparam logic [1:0] AluBRt      = 2'b00;
   localparam logic [1:0] AluBFour    = 2'b01;
   localparam logic [1:0] AluBImm     = 2'b10;
   localparam logic [1:0] AluBImmShl2 = 2'b11;

   function automatic logic [2:0] iTypeAluOp(input logic [5:0] op);
      unique case (op)
         OpAndi:  return AluAnd;
         OpOri:   return AluOr;
         OpLui:   return AluLui;
         default: return AluAdd;
      endcase
   endfunction

endpackage

// File: rtl/mc_opcode_decode.sv
// Combinational dispatch from DECODE: picks the execute state for an opcode/funct
// pair and flags opcodes the controller does not implement.
module mc_opcode_decode
   import mips_ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output stateT      nextState,
   output logic       illegal
);

   always_comb begin
      nextState = StFetch;
      illegal   = 1'b0;
      unique case (opcode)
         OpLw, OpSw:                     nextState = StMemAddr;
         OpRType:                        nextState = (funct == FunctJr) ? StJr : StRExec;
         OpBeq, OpBne:                   nextState = StBranch;
         OpJ:                            nextState = StJump;
         OpJal:                          nextState = StJal;
         OpAddi, OpAndi, OpOri, OpLui:   nextState = StIExec;
         default: begin
            nextState = StFetch;
            illegal   = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM with memory-ready handshaking, a sticky
// illegal-opcode flag and a retired-instruction counter.
module multicycle_control
   import mips_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_write,
   output logic             i_or_d,
   output logic             ir_write,
   output logic             pc_write,
   output logic             reg_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [2:0]       alu_op,
   output logic [1:0]       pc_source,
   output logic [1:0]       reg_dst,
   output logic [1:0]       mem_to_reg,
   output logic             illegal_op,
   output logic [CNT_W-1:0] instr_count,
   output logic [3:0]       state_out
);

   localparam logic [CNT_W-1:0] CntOne = 1;

   stateT            state, stateNext, decodeNext;
   logic             decodeIllegal, setIllegal, countEn;
   logic             illegalQ;
   logic [CNT_W-1:0] instrCount;
   logic             memReq, memWrite, irWrite, pcWrite, regWrite;

   mc_opcode_decode uDecode (
      .opcode    (opcode),
      .funct     (funct),
      .nextState (decodeNext),
      .illegal   (decodeIllegal)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= StFetch;
         instrCount <= '0;
         illegalQ   <= 1'b0;
      end else begin
         state <= stateNext;
         if (countEn)    instrCount <= instrCount + CntOne;
         if (setIllegal) illegalQ   <= 1'b1;
      end
   end

   always_comb begin
      stateNext  = state;
      setIllegal = 1'b0;
      memReq     = 1'b0;
      memWrite   = 1'b0;
      irWrite    = 1'b0;
      pcWrite    = 1'b0;
      regWrite   = 1'b0;
      i_or_d     = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = AluBRt;
      alu_op     = AluAdd;
      pc_source  = PcSrcAlu;
      reg_dst    = RegDstRt;
      mem_to_reg = MemToRegAluOut;
      unique case (state)
         StFetch: begin
            memReq    = 1'b1;
            alu_src_b = AluBFour;
            if (mem_ready) begin
               irWrite   = 1'b1;
               pcWrite   = 1'b1;
               stateNext = StDecode;
            end
         end
         StDecode: begin
            alu_src_b  = AluBImmShl2;
            stateNext  = decodeNext;
            setIllegal = decodeIllegal;
         end
         StMemAddr: begin
            alu_src_a = 1'b1;
            alu_src_b = AluBImm;
            stateNext = (opcode == OpSw) ? StMemWrite : StMemRead;
         end
         StMemRead: begin
            memReq = 1'b1;
            i_or_d = 1'b1;
            if (mem_ready) stateNext = StMemWb;
         end
         StMemWb: begin
            regWrite   = 1'b1;
            mem_to_reg = MemToRegMdr;
            stateNext  = StFetch;
         end
         StMemWrite: begin
            memReq   = 1'b1;
            memWrite = 1'b1;
            i_or_d   = 1'b1;
            if (mem_ready) stateNext = StFetch;
         end
         StRExec: begin
            alu_src_a = 1'b1;
            alu_op    = AluFunct;
            stateNext = StRWb;
         end
         StRWb: begin
            regWrite  = 1'b1;
            reg_dst   = RegDstRd;
            stateNext = StFetch;
         end
         StIExec: begin
            alu_src_a = 1'b1;
            alu_src_b = AluBImm;
            alu_op    = iTypeAluOp(opcode);
            stateNext = StIWb;
         end
         StIWb: begin
            regWrite  = 1'b1;
            stateNext = StFetch;
         end
         StBranch: begin
            alu_src_a = 1'b1;
            alu_op    = AluSub;
            pc_source = PcSrcAluOut;
            pcWrite   = (opcode == OpBne) ? ~zero : zero;
            stateNext = StFetch;
         end
         StJump: begin
            pcWrite   = 1'b1;
            pc_source = PcSrcJump;
            stateNext = StFetch;
         end
         StJal: begin
            pcWrite    = 1'b1;
            pc_source  = PcSrcJump;
            regWrite   = 1'b1;
            reg_dst    = RegDstRa;
            mem_to_reg = MemToRegPc;
            stateNext  = StFetch;
         end
         StJr: begin
            pcWrite   = 1'b1;
            pc_source = PcSrcRs;
            stateNext = StFetch;
         end
         default: stateNext = StFetch;
      endcase
   end

   // DECODE only falls back to FETCH on an illegal opcode, which must not retire.
   assign countEn = (state != StFetch) && (state != StDecode) && (stateNext == StFetch);

   // Reset forces FETCH, so its enables are masked while reset is held.
   assign mem_req   = memReq & ~reset;
   assign mem_write = memWrite & ~reset;
   assign ir_write  = irWrite & ~reset;
   assign pc_write  = pcWrite & ~reset;
   assign reg_write = regWrite & ~reset;

   assign illegal_op  = illegalQ;
   assign instr_count = instrCount;
   assign state_out   = state;

endmodule
